// File: rtl/lighthouse_array_if.sv
// Avalon-MM slave bus bundle used by the lighthouse sweep decoder register file.
interface lighthouse_array_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (output address, write, writedata, read, input readdata, waitrequest);
    modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/lighthouse_array.sv
// Multi-channel lighthouse sweep decoder: per-channel pulse classification into
// sync/sweep, sweep offset capture, and an Avalon-MM register file.
module lighthouse_array #(
    parameter int          NUM_SENSORS = 16,
    parameter int          ADDR_W      = 6,
    parameter int          CLK_DIV     = 50,
    parameter int          SYNC_MIN    = 50,
    parameter int          AXIS_THRESH = 90,
    parameter int          MAX_PULSE   = 400,
    parameter int          MAX_SWEEP   = 20000,
    // Timer value after reset; 0 in normal use, nonzero reaches the wrap point early.
    parameter logic [31:0] TIMER_INIT  = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    lighthouse_array_if.slave      avs,
    input  logic [NUM_SENSORS-1:0] sensor_i,
    output logic [NUM_SENSORS-1:0] data_available
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = $clog2(MAX_PULSE + 2);

    typedef enum logic [1:0] {IDLE, HIGH, EVAL, STUCK} state_t;

    logic [PW-1:0]          prescale;
    logic                   tick;
    logic [31:0]            timer;
    logic [NUM_SENSORS-1:0] s1, s2, s3, rise, fall;

    state_t                 state  [NUM_SENSORS];
    logic [31:0]            t_rise [NUM_SENSORS];
    logic [31:0]            t_sync [NUM_SENSORS];
    logic [WW-1:0]          width  [NUM_SENSORS];
    logic [31:0]            word   [NUM_SENSORS];
    logic [31:0]            d      [NUM_SENSORS];
    logic [31:0]            new_word [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] axis, sync_seen;

    logic [NUM_SENSORS-1:0] set_flag, err, enable, en_next, clr;
    logic [5:0]             err_pop;
    logic [32:0]            err_sum;
    logic [31:0]            errors, rd_mux;
    logic                   wr_en, wr_err, rd_flags;

    assign avs.waitrequest = 1'b0;
    assign tick = (prescale == PW'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale <= '0;
            timer    <= TIMER_INIT;
        end else begin
            prescale <= tick ? '0 : prescale + PW'(1);
            if (tick) timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= sensor_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Per-channel evaluation: what the EVAL (and overflow) cycle produces.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        set_flag = '0;
        err      = '0;
        for (int ch = 0; ch < NUM_SENSORS; ch++) begin
            d[ch]        = t_rise[ch] - t_sync[ch];
            new_word[ch] = {axis[ch],
                            (32'(width[ch]) > 32'd2047) ? 11'h7FF : 11'(width[ch]),
                            d[ch][19:0]};
            case (state[ch])
                HIGH: if (width[ch] > WW'(MAX_PULSE)) err[ch] = 1'b1;
                EVAL: begin
                    if (width[ch] > WW'(MAX_PULSE)) begin
                        err[ch] = 1'b1;
                    end else if (width[ch] < WW'(SYNC_MIN) && enable[ch]) begin
                        if (sync_seen[ch] && d[ch] <= 32'(MAX_SWEEP)) set_flag[ch] = 1'b1;
                        else                                            err[ch]      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every channel sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the sensor word array is reset because software reads it as 0 before any sweep.
            for (int ch = 0; ch < NUM_SENSORS; ch++) begin
                state[ch]  <= IDLE;
                t_rise[ch] <= '0;
                t_sync[ch] <= '0;
                width[ch]  <= '0;
                word[ch]   <= '0;
            end
            axis      <= '0;
            sync_seen <= '0;
        end else begin
            for (int ch = 0; ch < NUM_SENSORS; ch++) begin
                case (state[ch])
                    IDLE: if (rise[ch]) begin
                        t_rise[ch] <= timer;
                        width[ch]  <= '0;
                        state[ch]  <= HIGH;
                    end
                    HIGH: begin
                        if (tick && width[ch] <= WW'(MAX_PULSE)) width[ch] <= width[ch] + WW'(1);
                        if (width[ch] > WW'(MAX_PULSE)) state[ch] <= fall[ch] ? IDLE : STUCK;
                        else if (fall[ch])              state[ch] <= EVAL;
                    end
                    STUCK: if (fall[ch]) state[ch] <= IDLE;
                    EVAL: begin
                        if (width[ch] <= WW'(MAX_PULSE) && width[ch] >= WW'(SYNC_MIN)) begin
                            t_sync[ch]    <= t_rise[ch];
                            axis[ch]      <= (32'(width[ch]) >= 32'(AXIS_THRESH));
                            sync_seen[ch] <= 1'b1;
                        end
                        if (set_flag[ch]) word[ch] <= new_word[ch];
                        state[ch] <= IDLE;
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end

    assign wr_en    = avs.write && (32'(avs.address) == 32'(NUM_SENSORS + 1));
    assign wr_err   = avs.write && (32'(avs.address) == 32'(NUM_SENSORS + 2));
    assign rd_flags = avs.read  && (avs.address == '0);
    assign en_next  = wr_en ? avs.writedata[NUM_SENSORS-1:0] : enable;
    assign clr      = rd_flags ? data_available : '0;

    always_comb begin
        err_pop = '0;
        for (int ch = 0; ch < NUM_SENSORS; ch++) err_pop = err_pop + 6'(err[ch]);
    end

    assign err_sum = {1'b0, errors} + 33'(err_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            enable         <= '1;
            data_available <= '0;
            errors         <= '0;
        end else begin
            enable         <= en_next;
            // A flag set this cycle survives a simultaneous clearing read.
            data_available <= ((data_available & ~clr) | set_flag) & en_next;
            if (wr_err)          errors <= 32'(err_pop);
            else if (err_sum[32]) errors <= '1;
            else                 errors <= err_sum[31:0];
        end
    end

    always_comb begin
        rd_mux = 32'hDEADBEEF;
        if (avs.address == '0) rd_mux = 32'(data_available);
        for (int ch = 0; ch < NUM_SENSORS; ch++)
            if (32'(avs.address) == 32'(ch + 1)) rd_mux = word[ch];
        if (32'(avs.address) == 32'(NUM_SENSORS + 1)) rd_mux = 32'(enable);
        if (32'(avs.address) == 32'(NUM_SENSORS + 2)) rd_mux = errors;
    end

    always_ff @(posedge clock) begin
        if (reset)         avs.readdata <= '0;
        else if (avs.read) avs.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_lighthouse_array.sv
// Directed bench for lighthouse_array: table of single-channel decodes plus
// hand-written sequences for wrap, overlap, stuck, enable and reset corners.
module tb_lighthouse_array;

    localparam int NS = 16;
    localparam int EN_ADDR  = NS + 1;
    localparam int ERR_ADDR = NS + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] sensor = '0;
    logic [NS-1:0] data_available;
    logic [31:0]   v;
    int            total = 0;
    int            bad   = 0;

    lighthouse_array_if #(.ADDR_W(6)) bus ();

    lighthouse_array #(
        .NUM_SENSORS(NS), .ADDR_W(6), .CLK_DIV(1), .SYNC_MIN(50), .AXIS_THRESH(90),
        .MAX_PULSE(400), .MAX_SWEEP(20000), .TIMER_INIT(32'hFFFF_F000)
    ) dut (
        .clock(clock), .reset(reset), .avs(bus.slave),
        .sensor_i(sensor), .data_available(data_available)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          ch;
        int          sync_w;
        int          offset;
        int          sweep_w;
        logic [31:0] exp_word;
        logic [15:0] exp_flags;
        logic [31:0] exp_err;
    } row_t;

    row_t rows [8];

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input int a, output logic [31:0] val);
        bus.address = 6'(a);
        bus.read    = 1'b1;
        step(1);
        bus.read    = 1'b0;
        val         = bus.readdata;
    endtask

    task automatic bus_write(input int a, input logic [31:0] val);
        bus.address   = 6'(a);
        bus.writedata = val;
        bus.write     = 1'b1;
        step(1);
        bus.write     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
    endtask

    task automatic pulse(input int ch, input int w);
        sensor[ch] = 1'b1;
        step(w);
        sensor[ch] = 1'b0;
    endtask

    task automatic run_row(input int ch, input int sync_w, input int offset, input int sweep_w);
        if (sync_w > 0) begin
            pulse(ch, sync_w);
            step(offset - sync_w);
        end else begin
            step(offset);
        end
        pulse(ch, sweep_w);
        step(8);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rows[0] = '{0,  100, 4000,  10, 32'h80A00FA0, 16'h0001, 32'd0};
        rows[1] = '{7,  60,  500,   20, 32'h014001F4, 16'h0080, 32'd0};
        rows[2] = '{15, 90,  20000, 49, 32'h83104E20, 16'h8000, 32'd0};
        rows[3] = '{9,  90,  20001, 10, 32'h00000000, 16'h0000, 32'd1};
        rows[4] = '{4,  50,  100,   1,  32'h00100064, 16'h0010, 32'd0};
        rows[5] = '{2,  400, 1000,  5,  32'h805003E8, 16'h0004, 32'd0};
        rows[6] = '{6,  401, 1000,  5,  32'h00000000, 16'h0000, 32'd2};
        rows[7] = '{3,  0,   100,   10, 32'h00000000, 16'h0000, 32'd1};

        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        do_reset();
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_flags", 32'(data_available), 32'h0);
        bus_read(EN_ADDR, v);  check("reset_enable", v, 32'h0000FFFF);
        bus_read(ERR_ADDR, v); check("reset_err", v, 32'h0);
        bus_read(40, v);       check("unmapped", v, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_row(rows[i].ch, rows[i].sync_w, rows[i].offset, rows[i].sweep_w);
            check($sformatf("row%0d_flags_pin", i), 32'(data_available), 32'(rows[i].exp_flags));
            bus_read(rows[i].ch + 1, v); check($sformatf("row%0d_word", i), v, rows[i].exp_word);
            bus_read(0, v);        check($sformatf("row%0d_avail", i), v, 32'(rows[i].exp_flags));
            bus_read(0, v);        check($sformatf("row%0d_avail_clr", i), v, 32'h0);
            bus_read(ERR_ADDR, v); check($sformatf("row%0d_err", i), v, rows[i].exp_err);
        end
        bus_write(ERR_ADDR, 32'h1234);
        bus_read(ERR_ADDR, v); check("err_clear", v, 32'h0);

        // Sync and sweep straddling the 32-bit timer wrap.
        do_reset();
        step(3790);
        pulse(0, 100);
        step(32'h200 - 100);
        pulse(0, 10);
        step(8);
        bus_read(1, v); check("wrap_word", v, 32'h80A00200);

        // Two channels with errors in the same cycle, then simultaneous decodes.
        do_reset();
        sensor[2:1] = 2'b11; step(10); sensor[2:1] = 2'b00; step(8);
        bus_read(ERR_ADDR, v); check("err_popcount", v, 32'd2);
        sensor[2:1] = 2'b11; step(60); sensor[2:1] = 2'b00; step(440);
        sensor[2:1] = 2'b11; step(10); sensor[2:1] = 2'b00; step(8);
        check("simul_flags_pin", 32'(data_available), 32'h6);
        bus_read(2, v); check("simul_word2", v, 32'h00A001F4);
        bus_read(3, v); check("simul_word3", v, 32'h00A001F4);
        bus_read(0, v); check("simul_avail", v, 32'h6);

        // Ch2 lags ch1 by 5 cycles; the clearing read lands on ch2's completion cycle.
        sensor[1] = 1'b1; step(5); sensor[2] = 1'b1; step(55);
        sensor[1] = 1'b0; step(5); sensor[2] = 1'b0; step(435);
        sensor[1] = 1'b1; step(5); sensor[2] = 1'b1; step(5);
        sensor[1] = 1'b0; step(5); sensor[2] = 1'b0; step(3);
        bus_read(0, v); check("race_avail", v, 32'h2);
        check("race_flags_pin", 32'(data_available), 32'h4);
        bus_read(0, v); check("race_avail2", v, 32'h4);
        bus_read(3, v); check("race_word3", v, 32'h00A001F4);

        // Stuck-high channel, then normal recovery.
        do_reset();
        pulse(5, 1000); step(8);
        bus_read(ERR_ADDR, v); check("stuck_err", v, 32'd1);
        bus_read(0, v);        check("stuck_avail", v, 32'h0);
        bus_read(6, v);        check("stuck_word", v, 32'h0);
        run_row(5, 100, 300, 10);
        bus_read(6, v);        check("recover_word", v, 32'h80A0012C);
        bus_read(0, v);        check("recover_avail", v, 32'h20);

        // Disable ch0: flag drops, later sweeps are silent, syncs still tracked.
        do_reset();
        run_row(0, 100, 300, 10);
        bus_write(EN_ADDR, 32'h0000FFFE);
        check("disable_clears_flag", 32'(data_available), 32'h0);
        bus_read(EN_ADDR, v);  check("enable_rb", v, 32'h0000FFFE);
        run_row(0, 60, 500, 20);
        bus_read(0, v);        check("dis_avail", v, 32'h0);
        bus_read(ERR_ADDR, v); check("dis_err", v, 32'h0);
        bus_read(1, v);        check("dis_word", v, 32'h80A0012C);

        // Reset in the middle of a pulse.
        sensor[0] = 1'b1; step(20);
        reset = 1'b1; step(2);
        sensor[0] = 1'b0; step(5);
        reset = 1'b0; step(1);
        check("midrst_readdata", bus.readdata, 32'h0);
        check("midrst_flags", 32'(data_available), 32'h0);
        bus_read(EN_ADDR, v);  check("midrst_enable", v, 32'h0000FFFF);
        step(20);
        bus_read(ERR_ADDR, v); check("midrst_err", v, 32'h0);
        bus_read(1, v);        check("midrst_word", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
